// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, the IF/ID pipeline register,
// a saturating count of accepted instructions and a sticky address-error flag.
// Every cycle resolves to one action: REDIRECT, then HOLD, then ADVANCE, in priority order.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] instr_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic [31:0] fetch_cnt_o,
    output logic        addr_err_o
);

    // ifid_valid_o qualifies ifid_instr_o/ifid_pc4_o: it is 1 only while the
    // IF/ID register holds an instruction taken from memory. There is no ready
    // input; stall_i plays that role and holds the register contents in place.

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_plus4;
    logic        pc_out_of_range;

    assign pc_plus4        = pc_q + 32'd4;
    assign pc_out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);

    // Next-state selection: redirect wins over stall, stall wins over advance.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        addr_err_d   = addr_err_q;
        if (redirect_i) begin
            // Target is forced word-aligned; a misaligned request is still
            // honoured but flagged.
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            ifid_instr_d = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end
        end else if (!stall_i) begin
            pc_d         = pc_plus4;
            ifid_instr_d = instr_i;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            if (fetch_cnt_q != 32'hFFFF_FFFF) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            if (pc_out_of_range) begin
                addr_err_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset that overrides all requests.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'h0;
            addr_err_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign pc_addr_o    = pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_valid_o = ifid_valid_q;
    assign fetch_cnt_o  = fetch_cnt_q;
    assign addr_err_o   = addr_err_q;

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter IMEM_WORDS, default 32, giving the instruction memory depth in words for the out-of-range check.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, a synchronous, active-low reset.
REQ-005 The block SHALL have port stall_i, input, 1 bit, the hazard-detection stall request that holds the PC and IF/ID.
REQ-006 The block SHALL have port redirect_i, input, 1 bit, the taken-branch/jump request from a later stage.
REQ-007 The block SHALL have port redirect_pc_i, input, 32 bits, the redirect target address.
REQ-008 The block SHALL have port pc_addr_o, output, 32 bits, the current PC driven to the instruction memory address input.
REQ-009 The block SHALL have port instr_i, input, 32 bits, the instruction returned combinationally by the instruction memory for pc_addr_o.
REQ-010 The block SHALL have port ifid_instr_o, output, 32 bits, the registered IF/ID instruction.
REQ-011 The block SHALL have port ifid_pc4_o, output, 32 bits, the registered IF/ID value PC+4.
REQ-012 The block SHALL have port ifid_valid_o, output, 1 bit, set when the IF/ID holds a real fetched instruction.
REQ-013 The block SHALL have port fetch_cnt_o, output, 32 bits, the count of instructions accepted into IF/ID.
REQ-014 The block SHALL have port addr_err_o, output, 1 bit, a sticky flag for a misaligned or out-of-range fetch.

Function
REQ-015 pc_addr_o SHALL be the PC register output directly, with no combinational path from any input.
REQ-016 Each cycle SHALL resolve to exactly one of three actions: REDIRECT if redirect_i=1; else HOLD if stall_i=1; else ADVANCE.
REQ-017 REDIRECT SHALL load the PC with {redirect_pc_i[31:2],2'b00}.
REQ-018 REDIRECT SHALL load IF/ID with instr=32'h0, pc4=0 and valid=0 (bubble).
REQ-019 REDIRECT SHALL leave fetch_cnt_o unchanged.
REQ-020 redirect_i SHALL take priority over stall_i when both are asserted.
REQ-021 HOLD SHALL keep the PC, all IF/ID outputs and fetch_cnt_o unchanged.
REQ-022 ADVANCE SHALL load the PC with PC+4, computed modulo 2^32 so that 32'hFFFF_FFFC wraps to 0.
REQ-023 ADVANCE SHALL load ifid_instr_o with instr_i, ifid_pc4_o with PC+4, and set ifid_valid_o=1.
REQ-024 ADVANCE SHALL increment fetch_cnt_o by 1, saturating at 32'hFFFF_FFFF.
REQ-025 Latency SHALL be one cycle: the instruction at pc_addr_o in cycle N appears on ifid_instr_o in cycle N+1.
REQ-026 addr_err_o SHALL set when redirect_pc_i[1:0]!=0 during a REDIRECT; the target is still aligned and loaded.
REQ-027 addr_err_o SHALL set when an ADVANCE occurs with PC>>2 >= IMEM_WORDS.
REQ-028 addr_err_o SHALL remain set until reset.
REQ-029 stall_i asserted for K consecutive cycles SHALL freeze the state for exactly K cycles, and fetch SHALL resume at the held PC.

Reset
REQ-030 When rst_i=0 at a rising clk_i edge, the block SHALL set PC=RESET_PC, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, fetch_cnt_o=0 and addr_err_o=0, overriding stall_i and redirect_i.
REQ-031 Reset SHALL take effect on the edge even in the middle of a stall or redirect sequence, with no leftover state from before reset.
REQ-032 The first ADVANCE after rst_i returns to 1 SHALL fetch from RESET_PC.

Verification
REQ-033 Reset then 4 free cycles, memory word k=k+1 -> pc_addr_o steps 0,4,8,12,16; ifid_instr_o = 1,2,3,4 one cycle behind; fetch_cnt_o=4.
REQ-034 Stall for 3 cycles with PC=8 -> pc_addr_o stays 8 and IF/ID holds the instr at 4 with fetch_cnt_o frozen; on release the instr at 8 enters IF/ID.
REQ-035 Redirect to 32'h14 with stall also asserted, PC=8 -> next cycle PC=32'h14 and ifid_valid_o=0, ifid_instr_o=0; the following cycle ifid_pc4_o=32'h18.
REQ-036 Redirect to 32'h0000_0013 -> PC=32'h10 and addr_err_o=1, still 1 after 10 further cycles.
REQ-037 Advance past word 31 with IMEM_WORDS=32 -> addr_err_o=1; separately, force PC to 32'hFFFF_FFFC and advance -> PC=0.
REQ-038 rst_i=0 for one cycle during a stall with fetch_cnt_o=7 -> next cycle PC=0, fetch_cnt_o=0, ifid_valid_o=0.
